link_burst_master: RTL
======================

LINK_BURST_MASTER -- requirements
Module: link_burst_master

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, as the payload width in bits (range 1..64).
REQ-002 The block SHALL take parameter BURST_LEN, default 4, as the number of words per burst (range 1..256).
REQ-003 The block SHALL take parameter TIMEOUT, default 16, as the maximum number of REQ-state cycles without ack (0 disables the timeout).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a burst when sampled high in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: terminates the burst in progress.
REQ-008 The block SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, DATA_W bits): the payload source handshake.
REQ-009 The block SHALL have port ack, input, 1 bit: the slave acknowledge of the 4-phase link.
REQ-010 The block SHALL have ports req (output, 1 bit) and data (output, DATA_W bits): the link request and the link payload.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse on successful burst completion.
REQ-012 The block SHALL have ports busy (output, 1 bit) and err_timeout (output, 1 bit).
REQ-013 The block SHALL have port word_idx, output, clog2(BURST_LEN) bits (minimum 1 bit): the index of the current word.

Function
REQ-014 The block SHALL implement the states IDLE, FETCH, REQ, DROP, DONE, ERR and ABORT.
REQ-015 IDLE SHALL go to FETCH, clear word_idx and clear err_timeout when start=1; otherwise it holds.
REQ-016 FETCH SHALL drive in_ready=1, capture in_data into data on the in_valid=1 cycle, and enter REQ on the next cycle.
REQ-017 REQ SHALL drive req=1; on ack=1 it goes to DROP; each ack=0 cycle increments the wait counter.
REQ-018 The wait counter SHALL clear on entry to REQ; when TIMEOUT>0 and the counter reaches TIMEOUT-1 with ack=0, the block goes to ERR.
REQ-019 DROP SHALL drive req=0 and wait for ack=0; it then goes to DONE if word_idx==BURST_LEN-1, else increments word_idx and goes to FETCH.
REQ-020 DONE SHALL last exactly one cycle with done=1, then go to IDLE, with word_idx reset to 0.
REQ-021 ERR SHALL set err_timeout=1 (sticky until the next accepted start or reset), hold req=0, and go to ABORT.
REQ-022 ABORT SHALL hold req=0, wait for ack=0, then go to IDLE with done=0.
REQ-023 abort=1 in FETCH, REQ or DROP SHALL go to ABORT on the next edge; it has priority over ack, in_valid and timeout in the same cycle.
REQ-024 abort in IDLE, DONE or ABORT SHALL be ignored, and start outside IDLE SHALL be ignored.
REQ-025 in_ready SHALL be 1 only in FETCH, and req SHALL be 1 only in REQ.
REQ-026 data SHALL be a register, stable from entry to REQ until FETCH of the next word, and never changing while req=1.
REQ-027 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-028 All outputs except data and word_idx SHALL be Moore (state-decoded).
REQ-029 word_idx arithmetic SHALL never wrap past BURST_LEN-1.
REQ-030 With BURST_LEN=1, DROP SHALL go directly to DONE.
REQ-031 Minimum word cycle time SHALL be 4 clocks when in_valid is high in FETCH and ack responds in 1 cycle each phase.

Reset
REQ-032 rst=0 SHALL force, asynchronously: state IDLE, req=0, in_ready=0, done=0, busy=0, err_timeout=0, word_idx=0, data=0, wait counter=0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst without a done pulse; after release the block SHALL wait for a new start.
REQ-034 Reset release SHALL be synchronised to clk by the instantiating level; the block SHALL require no extra release logic.

Verification
REQ-035 The bench SHALL cover this default-parameter scenario: start pulse, in_data A0..A3 always valid, slave acks 1 cycle after req rise/fall -> four req pulses carrying data A0, A1, A2, A3, then a single done pulse, with busy falling on the next cycle.
REQ-036 The bench SHALL cover this scenario: TIMEOUT=16, ack held 0 -> req high exactly 16 cycles, err_timeout=1, no done, then IDLE; a later start clears err_timeout.
REQ-037 The bench SHALL cover this scenario: abort asserted in the same cycle as ack rises on word 2 -> ABORT taken, req drops, word_idx stays 2, no done, IDLE after ack falls.
REQ-038 The bench SHALL cover this scenario: in_valid low for 5 cycles in FETCH, and start pulsed while busy -> req stays 0 until in_valid, and the mid-burst start has no effect.
REQ-039 The bench SHALL cover this scenario: rst pulsed low while in REQ with ack=1 -> req=0 immediately (asynchronously), all outputs at reset values, and the block stays idle until start.
REQ-040 The bench SHALL cover this scenario: BURST_LEN=1, DATA_W=16, in_data=0xBEEF -> one handshake carrying 0xBEEF, then done.

Source files
------------

// File: rtl/link_burst_master.sv
// Burst master for a 4-phase req/ack link: fetches BURST_LEN words from a
// valid/ready source and hands each one over a full req/ack handshake.
module link_burst_master #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16,
    localparam int IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ack,
    output logic              req,
    output logic [DATA_W-1:0] data,
    output logic              done,
    output logic              busy,
    output logic              err_timeout,
    output logic [IDX_W-1:0]  word_idx
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_REQ, S_DROP, S_DONE, S_ERR, S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (in_valid) begin
                    data_d  = in_data;
                    wait_d  = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // abort outranks ack and timeout in the same cycle
                if (abort) begin
                    state_d = S_ABORT;
                end else if (ack) begin
                    state_d = S_DROP;
                end else if ((TIMEOUT > 0) && (wait_q == WAIT_LAST)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DROP: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if (!ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            S_ERR:   state_d = S_ABORT;
            S_ABORT: if (!ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_FETCH);
    assign req         = (state_q == S_REQ);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
    assign data        = data_q;
    assign word_idx    = idx_q;

endmodule
